mem_wb_stage: RTL

MEM/WB pipeline register and writeback stage of the 5-stage RV32I core; sits directly downstream of the memory stage and drives the register-file write port. Captures the memory stage's results on the clock edge, then aligns and sign/zero-extends the synchronous-read data word, which arrives one cycle after the address. Selects the writeback value, raises the store-data forward to the memory stage, and maintains a retired-instruction counter.

---
 rtl/mem_wb_stage.sv | 125 ++++++++++++
 1 files changed

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module   : mem_wb_stage
//  Brief    : MEM/WB pipeline register, load alignment/extension, writeback
//             select, store-data forward detect and retired-instruction count.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_wb_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        m_valid,
    input  logic        m_RegWrite,
    input  logic        m_MemRead,
    input  logic        m_MemWrite,
    input  logic [2:0]  m_funct3,
    input  logic [1:0]  m_addr_lo,
    input  logic [4:0]  m_rd,
    input  logic [4:0]  m_rs2,
    input  logic [31:0] reg_data_MEMWB,
    input  logic [31:0] read_data_MEMWB,
    output logic        wb_RegWrite,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        wb_forward,
    output logic        load_fault,
    output logic [31:0] instret
);

    logic        r_valid;
    logic        r_reg_write;
    logic        r_mem_read;
    logic [2:0]  r_funct3;
    logic [1:0]  r_addr_lo;
    logic [4:0]  r_rd;
    logic [31:0] r_reg_data;
    logic [31:0] r_instret;

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_aligned;
    logic        w_fault;
    logic        w_load_fault;
    logic        w_reg_write;

    // Flush only kills valid; the payload fields are don't-care for a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_funct3    <= 3'd0;
            r_addr_lo   <= 2'd0;
            r_rd        <= 5'd0;
            r_reg_data  <= 32'd0;
        end else if (flush) begin
            r_valid     <= 1'b0;
        end else if (!stall) begin
            r_valid     <= m_valid;
            r_reg_write <= m_RegWrite;
            r_mem_read  <= m_MemRead;
            r_funct3    <= m_funct3;
            r_addr_lo   <= m_addr_lo;
            r_rd        <= m_rd;
            r_reg_data  <= reg_data_MEMWB;
        end
    end

    // The WB instruction retires whenever it leaves the stage: either it
    // advances normally or a flush replaces it with a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instret <= 32'd0;
        end else if (r_valid && (!stall || flush)) begin
            r_instret <= r_instret + 32'd1;
        end
    end

    always_comb begin
        w_byte    = 8'd0;
        w_half    = 16'd0;
        w_aligned = 32'd0;
        w_fault   = 1'b0;
        case (r_addr_lo)
            2'd0:    w_byte = read_data_MEMWB[7:0];
            2'd1:    w_byte = read_data_MEMWB[15:8];
            2'd2:    w_byte = read_data_MEMWB[23:16];
            default: w_byte = read_data_MEMWB[31:24];
        endcase
        w_half = r_addr_lo[1] ? read_data_MEMWB[31:16] : read_data_MEMWB[15:0];
        case (r_funct3)
            3'b000: w_aligned = {{24{w_byte[7]}}, w_byte};
            3'b100: w_aligned = {24'd0, w_byte};
            3'b001: begin
                w_aligned = {{16{w_half[15]}}, w_half};
                w_fault   = r_addr_lo[0];
            end
            3'b101: begin
                w_aligned = {16'd0, w_half};
                w_fault   = r_addr_lo[0];
            end
            3'b010: begin
                w_aligned = read_data_MEMWB;
                w_fault   = |r_addr_lo;
            end
            default: begin
                w_aligned = 32'd0;
                w_fault   = 1'b1;
            end
        endcase
    end

    assign w_load_fault = r_valid & r_mem_read & w_fault;
    assign w_reg_write  = r_valid & r_reg_write & (r_rd != 5'd0) & ~w_load_fault;

    assign wb_data     = r_mem_read ? (w_fault ? 32'd0 : w_aligned) : r_reg_data;
    assign wb_rd       = r_rd;
    assign wb_RegWrite = w_reg_write;
    assign load_fault  = w_load_fault;
    assign wb_forward  = w_reg_write & m_MemWrite & m_valid & (r_rd == m_rs2);
    assign instret     = r_instret;

endmodule
`default_nettype wire
